// File: rtl/alu_multicycle_if.sv
// Handshaked operand/result bus of the multi-cycle EX-stage ALU.
interface alu_multicycle_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       operation;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Result;
  logic             ZERO;
  logic             OVF;

  // Pipeline side: presents operands, consumes results.
  modport master (
    output in_valid, a, b, operation, out_ready,
    input  in_ready, out_valid, Result, ZERO, OVF
  );

  // ALU side.
  modport slave (
    input  in_valid, a, b, operation, out_ready,
    output in_ready, out_valid, Result, ZERO, OVF
  );
endinterface

// File: rtl/alu_multicycle.sv
// Multi-cycle EX-stage ALU: single-cycle logic/add/sub/shift ops and an
// iterative shift-add multiplier, with a registered Result/ZERO/OVF and a
// valid/ready handshake on both sides.
module alu_multicycle #(
  parameter int WIDTH = 64,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic             clk,
  input logic             reset,
  alu_multicycle_if.slave bus
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_MUL = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLL = 4'b1000;
  localparam logic [3:0] OP_SRL = 4'b1001;
  localparam logic [3:0] OP_SRA = 4'b1010;
  localparam logic [3:0] OP_NOR = 4'b1100;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t           state, state_nxt;
  logic             accept;
  logic             is_mul_in;
  logic             last_iter;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mul_sum;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic [SHW-1:0]   shamt;

  assign accept    = bus.in_valid & bus.in_ready;
  assign is_mul_in = (bus.operation == OP_MUL);
  assign last_iter = (state == EXEC) && (cnt == SHW'(WIDTH - 1));
  assign shamt     = bus.b[SHW-1:0];
  // One multiplier bit per cycle: mcand already holds a<<cnt, mplier[0] is b[cnt].
  assign mul_sum   = acc + (mplier[0] ? mcand : '0);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses <= so every flop samples pre-edge values.
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    // NOTE: default first so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = is_mul_in ? EXEC : DONE;
      EXEC:    if (last_iter) state_nxt = DONE;
      DONE: begin
        if (bus.out_ready) begin
          if (accept) state_nxt = is_mul_in ? EXEC : DONE;
          else        state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs; in_ready is the only path that depends on out_ready.
  always_comb begin
    bus.in_ready  = (state == IDLE) || ((state == DONE) && bus.out_ready);
    bus.out_valid = (state == DONE);
  end

  // Single-cycle result and signed-overflow for the non-MUL opcodes.
  always_comb begin
    sum     = bus.a + bus.b;
    diff    = bus.a - bus.b;
    alu_res = '0;
    alu_ovf = 1'b0;
    case (bus.operation)
      OP_AND: alu_res = bus.a & bus.b;
      OP_OR:  alu_res = bus.a | bus.b;
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SLL: alu_res = bus.a << shamt;
      OP_SRL: alu_res = bus.a >> shamt;
      OP_SRA: alu_res = $unsigned($signed(bus.a) >>> shamt);
      OP_NOR: alu_res = ~(bus.a | bus.b);
      default: alu_res = '0;  // MUL finishes later; undefined codes give 0
    endcase
  end

  // Multiplier operand shifters, loaded on a MUL accept.
  always_ff @(posedge clk) begin
    // NOTE: pure datapath regs, always loaded before use, so they carry no reset.
    if (accept && is_mul_in) begin
      mcand  <= bus.a;
      mplier <= bus.b;
    end else if (state == EXEC) begin
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

  // Result/flag registers, accumulator and iteration counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.Result <= '0;
      bus.ZERO   <= 1'b0;
      bus.OVF    <= 1'b0;
      acc        <= '0;
      cnt        <= '0;
    end else if (accept) begin
      if (is_mul_in) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        bus.Result <= alu_res;
        bus.ZERO   <= (alu_res == '0);
        bus.OVF    <= alu_ovf;
      end
    end else if (state == EXEC) begin
      acc <= mul_sum;
      cnt <= cnt + SHW'(1);
      if (last_iter) begin
        bus.Result <= mul_sum;
        bus.ZERO   <= (mul_sum == '0);
        bus.OVF    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: a 64-bit and an 8-bit instance,
// table-driven vectors plus hand sequences, results checked via scoreboards.
module tb_alu_multicycle;

  typedef struct {
    logic [63:0] res;
    logic        zero;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    exp_t        e;
  } vec_t;

  logic clk;
  logic reset64;
  logic reset8;
  int   checks   = 0;
  int   failures = 0;
  exp_t q64[$];
  exp_t q8[$];
  vec_t vecs[20];

  alu_multicycle_if #(.WIDTH(64)) bus64 ();
  alu_multicycle_if #(.WIDTH(8))  bus8  ();

  alu_multicycle #(.WIDTH(64)) u_dut64 (.clk(clk), .reset(reset64), .bus(bus64));
  alu_multicycle #(.WIDTH(8))  u_dut8  (.clk(clk), .reset(reset8),  .bus(bus8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t mk_e(input logic [63:0] r, input logic z, input logic o);
    exp_t e;
    e.res = r; e.zero = z; e.ovf = o;
    return e;
  endfunction

  function automatic vec_t mk_v(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                                input logic [63:0] r, input logic z, input logic o);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.e = mk_e(r, z, o);
    return v;
  endfunction

  // Scoreboard for the 64-bit instance: compare on each handshake.
  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (bus64.out_valid && bus64.out_ready) begin
      if (q64.size() == 0) check("out64_expected", 64'(q64.size()), 64'd1);
      else begin
        e = q64.pop_front();
        check("res64", bus64.Result, e.res);
        check("zero64", 64'(bus64.ZERO), 64'(e.zero));
        check("ovf64", 64'(bus64.OVF), 64'(e.ovf));
      end
    end
  end

  // Scoreboard for the 8-bit instance.
  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (bus8.out_valid && bus8.out_ready) begin
      if (q8.size() == 0) check("out8_expected", 64'(q8.size()), 64'd1);
      else begin
        e = q8.pop_front();
        check("res8", 64'(bus8.Result), e.res);
        check("zero8", 64'(bus8.ZERO), 64'(e.zero));
        check("ovf8", 64'(bus8.OVF), 64'(e.ovf));
      end
    end
  end

  // Called at a negedge; holds the op until accepted, returns at the negedge after accept.
  task automatic send64(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                        input exp_t e, input bit push);
    int n = 0;
    bus64.operation = op; bus64.a = a; bus64.b = b; bus64.in_valid = 1'b1;
    #1;
    while (!bus64.in_ready && n < 500) begin
      @(negedge clk); #1; n++;
    end
    if (!bus64.in_ready) begin
      check("accept64", 64'(bus64.in_ready), 64'd1);
      bus64.in_valid = 1'b0;
      return;
    end
    if (push) q64.push_back(e);
    @(posedge clk);
    @(negedge clk);
    bus64.in_valid = 1'b0;
  endtask

  task automatic send8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input exp_t e, input bit push);
    int n = 0;
    bus8.operation = op; bus8.a = a; bus8.b = b; bus8.in_valid = 1'b1;
    #1;
    while (!bus8.in_ready && n < 500) begin
      @(negedge clk); #1; n++;
    end
    if (!bus8.in_ready) begin
      check("accept8", 64'(bus8.in_ready), 64'd1);
      bus8.in_valid = 1'b0;
      return;
    end
    if (push) q8.push_back(e);
    @(posedge clk);
    @(negedge clk);
    bus8.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q64.size() != 0 || q8.size() != 0) && n < 400) begin
      @(negedge clk); n++;
    end
    check("drain", 64'(q64.size() + q8.size()), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    logic seen;

    vecs[0]  = mk_v(4'b0000, 64'hF0, 64'h3C, 64'h30, 1'b0, 1'b0);
    vecs[1]  = mk_v(4'b0001, 64'hF0, 64'h0F, 64'hFF, 1'b0, 1'b0);
    vecs[2]  = mk_v(4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    vecs[3]  = mk_v(4'b0010, 64'd5, 64'd7, 64'd12, 1'b0, 1'b0);
    vecs[4]  = mk_v(4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1, 1'b0);
    vecs[5]  = mk_v(4'b0110, 64'h1234, 64'h1234, 64'd0, 1'b1, 1'b0);
    vecs[6]  = mk_v(4'b0110, 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
    vecs[7]  = mk_v(4'b0110, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    vecs[8]  = mk_v(4'b1000, 64'd1, 64'h41, 64'd2, 1'b0, 1'b0);
    vecs[9]  = mk_v(4'b1000, 64'd1, 64'd63, 64'h8000_0000_0000_0000, 1'b0, 1'b0);
    vecs[10] = mk_v(4'b1001, 64'h8000_0000_0000_0000, 64'd4, 64'h0800_0000_0000_0000, 1'b0, 1'b0);
    vecs[11] = mk_v(4'b1010, 64'h8000_0000_0000_0000, 64'd4, 64'hF800_0000_0000_0000, 1'b0, 1'b0);
    vecs[12] = mk_v(4'b1010, 64'h8000_0000_0000_0000, 64'h43, 64'hF000_0000_0000_0000, 1'b0, 1'b0);
    vecs[13] = mk_v(4'b1100, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    vecs[14] = mk_v(4'b1100, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0, 1'b1, 1'b0);
    vecs[15] = mk_v(4'b0011, 64'd3, 64'd5, 64'd15, 1'b0, 1'b0);
    vecs[16] = mk_v(4'b0011, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
    vecs[17] = mk_v(4'b0100, 64'd5, 64'd5, 64'd0, 1'b1, 1'b0);
    vecs[18] = mk_v(4'b1111, 64'hFF, 64'h1, 64'd0, 1'b1, 1'b0);
    vecs[19] = mk_v(4'b0111, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1, 1'b0);

    reset64 = 1'b1; reset8 = 1'b1;
    bus64.in_valid = 1'b0; bus64.a = '0; bus64.b = '0; bus64.operation = '0; bus64.out_ready = 1'b1;
    bus8.in_valid  = 1'b0; bus8.a  = '0; bus8.b  = '0; bus8.operation  = '0; bus8.out_ready  = 1'b1;

    // Reset then idle.
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset64 = 1'b0; reset8 = 1'b0;
    #1;
    check("rst_out_valid", 64'(bus64.out_valid), 64'd0);
    check("rst_result", bus64.Result, 64'd0);
    check("rst_zero", 64'(bus64.ZERO), 64'd0);
    check("rst_ovf", 64'(bus64.OVF), 64'd0);
    check("rst_in_ready", 64'(bus64.in_ready), 64'd1);
    check("rst8_out_valid", 64'(bus8.out_valid), 64'd0);
    check("rst8_in_ready", 64'(bus8.in_ready), 64'd1);
    @(negedge clk);

    // ADD overflow, latency 1.
    send64(4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, mk_e(64'h8000_0000_0000_0000, 1'b0, 1'b1), 1'b1);
    check("add_latency1_valid", 64'(bus64.out_valid), 64'd1);
    drain();

    // Table of vectors, issued back-to-back.
    for (int i = 0; i < 20; i++) send64(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].e, 1'b1);
    drain();

    // MUL timing: busy for WIDTH cycles, valid after edge E0+64.
    send64(4'b0011, 64'd123456789, 64'd1000, mk_e(64'd123456789000, 1'b0, 1'b0), 1'b1);
    ok = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (bus64.out_valid || bus64.in_ready) ok = 1'b0;
      @(negedge clk);
    end
    check("mul_busy_64_cycles", 64'(ok), 64'd1);
    check("mul_valid_after_64", 64'(bus64.out_valid), 64'd1);
    drain();

    // Backpressure: result held, in_ready low.
    bus64.out_ready = 1'b0;
    send64(4'b0010, 64'd5, 64'd7, mk_e(64'd12, 1'b0, 1'b0), 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("bp_result", bus64.Result, 64'd12);
      check("bp_in_ready", 64'(bus64.in_ready), 64'd0);
      check("bp_out_valid", 64'(bus64.out_valid), 64'd1);
      @(negedge clk);
    end
    // Release with a simultaneous new op: accepted on the same edge.
    bus64.out_ready = 1'b1;
    send64(4'b0000, 64'hF0, 64'h3C, mk_e(64'h30, 1'b0, 1'b0), 1'b1);
    check("b2b_out_valid", 64'(bus64.out_valid), 64'd1);
    check("b2b_result", bus64.Result, 64'h30);
    @(negedge clk);
    // Handshake without a new op: IDLE, result retained.
    check("idle_out_valid", 64'(bus64.out_valid), 64'd0);
    check("idle_result_kept", bus64.Result, 64'h30);
    check("idle_in_ready", 64'(bus64.in_ready), 64'd1);
    drain();

    // Reset in the middle of a MUL: no output at all.
    send64(4'b0011, 64'd99, 64'd77, mk_e(64'd0, 1'b0, 1'b0), 1'b0);
    repeat (9) @(negedge clk);
    check("mid_mul_busy", 64'(bus64.in_ready), 64'd0);
    reset64 = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset64 = 1'b0;
    #1;
    check("abort_in_ready", 64'(bus64.in_ready), 64'd1);
    check("abort_result", bus64.Result, 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (bus64.out_valid) seen = 1'b1;
      @(negedge clk);
    end
    check("abort_no_pulse", 64'(seen), 64'd0);
    // A fresh MUL after the abort starts from a clean accumulator/counter.
    send64(4'b0011, 64'd3, 64'd5, mk_e(64'd15, 1'b0, 1'b0), 1'b1);
    drain();

    // WIDTH=8 instance.
    send8(4'b0011, 8'd15, 8'd17, mk_e(64'hFF, 1'b0, 1'b0), 1'b1);
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (bus8.out_valid) ok = 1'b0;
      @(negedge clk);
    end
    check("mul8_busy_8_cycles", 64'(ok), 64'd1);
    check("mul8_valid_after_8", 64'(bus8.out_valid), 64'd1);
    drain();
    send8(4'b0010, 8'h80, 8'h80, mk_e(64'h00, 1'b1, 1'b1), 1'b1);
    send8(4'b1010, 8'h80, 8'h0B, mk_e(64'hF0, 1'b0, 1'b0), 1'b1);
    send8(4'b0110, 8'h7F, 8'hFF, mk_e(64'h80, 1'b0, 1'b1), 1'b1);
    send8(4'b0011, 8'd16, 8'd16, mk_e(64'h00, 1'b1, 1'b0), 1'b1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
